// File: rtl/sram22_pkg.sv
// Shared types, constants and helpers for the parametrised SRAM22 model.
// Holds the init FSM state enum, legal read latencies and wmask expansion.
package sram22_pkg;

    // Zero-fill sequencer states; RUN is terminal until reset.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } init_state_e;

    // Legal read pipeline depths.
    localparam int RL_MIN = 1;
    localparam int RL_MAX = 2;

    // Upper bounds for the generic mask expander.
    localparam int MASK_MAX_DW    = 1024;
    localparam int MASK_MAX_LANES = 128;

    // Expand a per-lane write mask into a per-bit mask.
    // Bits beyond lanes*lane_w are left at zero.
    function automatic logic [MASK_MAX_DW-1:0] expand_wmask(
        input logic [MASK_MAX_LANES-1:0] wm,
        input int                        lanes,
        input int                        lane_w
    );
        logic [MASK_MAX_DW-1:0] m;
        logic [6:0]             lane_idx;
        m = '0;
        for (int i = 0; i < MASK_MAX_DW; i++) begin
            if (lane_w > 0 && (i / lane_w) < lanes) begin
                lane_idx   = 7'(i / lane_w);
                m[i[9:0]]  = wm[lane_idx];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sram22_init_seq.sv
// Post-reset zero-fill sequencer: walks every address once, then RUN.
// Ports: clk, rstb (async low), init_we/init_addr (sweep write), ready.
module sram22_init_seq
    import sram22_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstb,
    output logic                  init_we,
    output logic [ADDR_WIDTH-1:0] init_addr,
    output logic                  ready
);

    init_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        unique case (state_q)
            INIT: begin
                init_we = 1'b1;
                // Last address written on this edge: stop, never wrap.
                if (cnt_q == '1) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_addr = cnt_q;
    assign ready     = (state_q == RUN);

endmodule

// File: rtl/sram22_param_sram.sv
// Parametrised single-port SRAM22 behavioural model with zero-fill,
// lane write mask, 1/2-cycle read pipeline and optional write readback.
// Ports: clk, rstb, ce, we, wmask, addr, din -> dout, dout_valid, ready.
module sram22_param_sram
    import sram22_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int WMASK_WIDTH    = 4,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_READBACK = 0
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   ce,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   ready
);

    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam int MW_SAFE  = (WMASK_WIDTH > 0) ? WMASK_WIDTH : 1;
    localparam int LANE_W   = DATA_WIDTH / MW_SAFE;
    localparam int LANE_REM = DATA_WIDTH % MW_SAFE;
    localparam logic WB_EN  = (WRITE_READBACK != 0);

    generate
        if (WMASK_WIDTH < 1 || WMASK_WIDTH > MASK_MAX_LANES) begin : g_err_mw
            $error("sram22: WMASK_WIDTH out of range");
        end
        if (LANE_REM != 0) begin : g_err_lane
            $error("sram22: DATA_WIDTH not a multiple of WMASK_WIDTH");
        end
        if (DATA_WIDTH < 1 || DATA_WIDTH > MASK_MAX_DW) begin : g_err_dw
            $error("sram22: DATA_WIDTH out of range");
        end
        if (READ_LATENCY != RL_MIN && READ_LATENCY != RL_MAX) begin : g_err_rl
            $error("sram22: READ_LATENCY must be 1 or 2");
        end
        if (ADDR_WIDTH < 1) begin : g_err_aw
            $error("sram22: ADDR_WIDTH must be at least 1");
        end
    endgenerate

    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_addr;

    sram22_init_seq #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_init_seq (
        .clk      (clk),
        .rstb     (rstb),
        .init_we  (init_we),
        .init_addr(init_addr),
        .ready    (ready)
    );

    // Array is deliberately left out of reset; the sweep clears it.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  accept;
    logic                  produce;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] user_bmask;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] out_word;

    assign user_bmask = DATA_WIDTH'(expand_wmask(
        MASK_MAX_LANES'(wmask), WMASK_WIDTH, LANE_W));

    always_comb begin
        accept      = ce & ready;
        rd_word     = mem_q[addr];
        merged_word = (rd_word & ~user_bmask) | (din & user_bmask);
        out_word    = we ? merged_word : rd_word;
        produce     = accept & (~we | WB_EN);
        // Sweep owns the port while in INIT; user requests are dropped.
        mem_we      = init_we | (accept & we);
        mem_addr    = init_we ? init_addr : addr;
        mem_wdata   = init_we ? '0 : merged_word;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;

    always_comb begin
        s1_valid_d   = 1'b0;
        s1_data_d    = s1_data_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (READ_LATENCY == RL_MIN) begin
            if (produce) begin
                dout_d       = out_word;
                dout_valid_d = 1'b1;
            end
        end else begin
            // Word is captured at accept, so later writes cannot disturb it.
            s1_valid_d = produce;
            if (produce) begin
                s1_data_d = out_word;
            end
            if (s1_valid_q) begin
                dout_d       = s1_data_q;
                dout_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: doc/sram22_param_sram.md
Name: sram22_param_sram

Overview:
- Parametrised, synthesizable behavioural model of an SRAM22 single-port macro. Successor to the fixed-size macro models.
- Adds configurable width, depth and mask granularity, plus a post-reset zero-fill sweep with a ready flag.
- Adds a selectable 1- or 2-cycle read pipeline with a dout_valid strobe, and optional write-through readback.
- Used as the drop-in memory model for any SRAM22 macro configuration in RTL simulation and FPGA prototyping.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of WMASK_WIDTH.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH.
- WMASK_WIDTH, 4, number of write-mask lanes; lane width = DATA_WIDTH/WMASK_WIDTH.
- READ_LATENCY, 1, cycles from accepted read to dout update; legal values 1 or 2.
- WRITE_READBACK, 0, if 1, an accepted write also returns the merged post-write word on dout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstb  in  1  reset bar; asynchronous assert, active low.
- ce  in  1  chip enable; a request is accepted when ce=1 and ready=1.
- we  in  1  write enable; 1 = write, 0 = read.
- wmask  in  WMASK_WIDTH  per-lane write enable; bit i covers din[i*L +: L], where L = lane width.
- addr  in  ADDR_WIDTH  word address.
- din  in  DATA_WIDTH  write data.
- dout  out  DATA_WIDTH  read data; holds its value between reads.
- dout_valid  out  1  one-cycle strobe; high in the cycle dout carries new data.
- ready  out  1  high once the zero-fill sweep is complete.

Behaviour:
- Reset (rstb=0, asynchronous):
  - dout=0, dout_valid=0, ready=0.
  - Read pipeline stages cleared; init counter cleared to 0.
  - Memory array itself is not reset.
- Init FSM states: INIT, RUN.
  - After rstb deasserts, the FSM is in INIT.
  - INIT writes all-zero words to addresses 0 .. 2**ADDR_WIDTH-1, one per cycle, in ascending order.
  - INIT->RUN on the edge that writes the last address; ready rises in that same edge, so it is seen in the next cycle.
  - Init takes exactly 2**ADDR_WIDTH cycles.
  - The counter does not wrap; RUN is terminal until the next reset.
- In INIT, ce/we/addr/din are ignored, no request is accepted, and dout and dout_valid are unchanged.
- Write (accepted, we=1):
  - Only lanes with wmask[i]=1 are updated; wmask=0 is a legal no-op write.
  - If WRITE_READBACK=0, dout is untouched and no dout_valid is generated.
  - If WRITE_READBACK=1, the merged word (new lanes plus old lanes) is returned exactly like a read, with the same latency and a dout_valid strobe.
- Read (accepted, we=0):
  - The array is sampled at the accept edge.
  - READ_LATENCY=1: dout is updated and dout_valid=1 on that same edge.
  - READ_LATENCY=2: data passes through one extra register; dout is updated one edge later.
  - Back-to-back reads run at full throughput, one per cycle, in order.
- Read sampling is never disturbed by later writes. With READ_LATENCY=2, read A then write A in the next cycle returns the old A.
- Accepted cycles with ce=0, or cycles in INIT, leave dout holding its value and drive dout_valid=0 in the corresponding output cycle.
- Reset during INIT or with reads in flight:
  - In-flight reads are discarded and no dout_valid is produced for them.
  - The sweep restarts from address 0.
- Elaboration errors:
  - DATA_WIDTH % WMASK_WIDTH != 0.
  - READ_LATENCY not in {1,2}.
  - ADDR_WIDTH < 1.
- Out-of-range addresses are impossible by construction; every addr value is valid.

Decomposition:
- Package sram22_pkg holds:
  - the init state enum {INIT, RUN};
  - a function expanding wmask into a DATA_WIDTH bit mask;
  - the legal-latency constants.
- Sub-module sram22_init_seq: the ADDR_WIDTH-bit counter plus FSM, producing init_we, init_addr and ready.
- The top level muxes init traffic against user traffic into the array and holds the read pipeline.

Test Plan:
- Zero-fill after reset (defaults): release rstb at t0 -> ready=0 for exactly 256 cycles, then 1; read addr 0x00 and 0xFF -> dout=0x00000000 with one dout_valid pulse each.
- Masked write (defaults, READ_LATENCY=1): write 0x11223344 to addr 0x05 with wmask=4'b1111, then write 0xAABBCCDD with wmask=4'b0101, then read 0x05 -> dout=0x11BB33DD one cycle after the read accept.
- Pipelined throughput (READ_LATENCY=2): after filling addr k with k for k=0..3, issue reads 0,1,2,3 on consecutive cycles -> dout=0,1,2,3 on consecutive cycles starting 2 cycles after the first accept; dout_valid high for exactly 4 cycles.
- Write-through (WRITE_READBACK=1): addr 0x10 holds 0; write 0x0000FFFF with wmask=4'b0011 -> dout=0x0000FFFF with dout_valid after READ_LATENCY; a plain write with WRITE_READBACK=0 -> dout unchanged and no strobe.
- Requests during init: drive ce=1, we=1, addr=0x03, din=0xDEADBEEF for the first 10 cycles of INIT -> ignored; after ready, read 0x03 -> 0x00000000.
- Reset mid-operation (READ_LATENCY=2): assert rstb low one cycle after a read accept -> dout=0 and dout_valid=0 immediately with no later strobe; ready drops and the 256-cycle sweep reruns.
